// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owners
// and the round-robin grant rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int unsigned CNT_W = 2;

  // On a tie the port that did not win last time is granted.
  function automatic owner_e rr_pick(logic if_req, logic d_req, owner_e last_grant);
    if (if_req && d_req) return (last_grant == OWN_IF) ? OWN_D : OWN_IF;
    else if (d_req)      return OWN_D;
    else                 return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the multicycle CPU's single memory between instruction fetch and
// load/store, sequencing each access as IDLE -> ISSUE -> (WAIT) -> DONE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  owner_e            grant_d;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_valid_q;
  logic              d_valid_q;
  logic              busy_q;

  always_comb begin
    grant_d = rr_pick(if_req, d_req, last_grant_q);
  end

  // mem_addr_q/mem_wdata_q double as the transaction latch; they are cleared
  // on the way back to IDLE so the memory pins read 0 between accesses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_D;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            state_q <= ISSUE;
            owner_q <= grant_d;
            busy_q  <= 1'b1;
            if (grant_d == OWN_D) begin
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              we_q        <= d_we;
              mem_we_q    <= d_we;
            end else begin
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              we_q        <= 1'b0;
              mem_we_q    <= 1'b0;
            end
          end
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          if (we_q) begin
            state_q   <= DONE;
            d_valid_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (owner_q == OWN_IF) begin
              if_rdata_q <= mem_rdata;
              if_valid_q <= 1'b1;
            end else begin
              d_rdata_q <= mem_rdata;
              d_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          last_grant_q <= owner_q;
          busy_q       <= 1'b0;
          we_q         <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = mem_we_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if_valid  = if_valid_q;
    d_valid   = d_valid_q;
    busy      = busy_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory of the multicycle CPU between the instruction-fetch path (FETCH state) and the data path (LW/SW). It sequences each access as issue, wait and respond, and hides the memory's fixed read latency behind a request/valid handshake. It resolves contention with round-robin priority. It sits between the control unit/datapath and the memory macro, and drives all memory address, data and write-enable pins.

## Interface
- ADDR_W, 8, word-address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetched word; holds its last value
- if_valid  out  1  one-cycle completion pulse for the fetch port
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store (SW), 0 = load (LW); stable with d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load result; holds its last value
- d_valid  out  1  one-cycle completion pulse for the data port
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the address is presented
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is high, latch owner, address, we and wdata, then go to ISSUE.
  - If both requests are high, grant the port that is not last_grant.
  - last_grant resets to DATA, so the first tie after reset goes to fetch.
- ISSUE:
  - mem_addr = latched address; mem_we = latched we (always 0 for the fetch owner).
  - Store → DONE. Load/fetch → WAIT, with counter loaded to MEM_LAT-1.
- WAIT:
  - mem_addr held and mem_we = 0.
  - Counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE:
  - Pulse the owner's valid; update last_grant; go to IDLE.
  - A store does not modify d_rdata.
- Requester contract:
  - A requester drops req in the cycle after its valid pulse, or keeps it high to issue a new request.
  - Request inputs are sampled only in IDLE.
- mem_addr and mem_wdata equal the latched values in every non-IDLE state and are 0 in IDLE.
- A fetch request is never a write, regardless of the d_* pins.

## Timing
- Reset values: state IDLE; if_rdata, d_rdata, if_valid, d_valid, mem_addr, mem_wdata, mem_we and busy all 0; last_grant DATA; counter 0.
- Cycle numbering: request first high in IDLE at cycle 0.
- Load/fetch: ISSUE at cycle 1; WAIT from cycle 2 to 1+MEM_LAT; valid at 2+MEM_LAT.
- Store: mem_we high only in cycle 1; d_valid in cycle 2.
- Turnaround: IDLE always lasts at least one cycle between transactions. Read throughput is one transaction per 3+MEM_LAT cycles.
- Reset low mid-transaction: the next cycle is IDLE with all outputs at their reset values. No valid pulse is produced, and a store in ISSUE is not completed.
- Request arriving in a non-IDLE state: ignored until the next IDLE; it is not lost as long as the requester keeps req high.

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3) and owner constants (OWN_IF=1'b0, OWN_D=1'b1).
- Single module; no sub-module is natural. The latency counter is a 2-bit register inside the block.

## Test plan
- Reset: hold reset=0 for 3 cycles with both requests high → all outputs 0, busy 0, no valid pulse.
- Fetch, MEM_LAT=1, mem[0x10]=0xDEADBEEF: if_req at cycle 0 → mem_addr=0x10 in cycles 1–2, if_valid in cycle 3, if_rdata=0xDEADBEEF, mem_we never high.
- Store then load: store d_addr=0x20, d_wdata=0x12345678 → mem_we high only in cycle 1, d_valid in cycle 2. Then load 0x20 → d_rdata=0x12345678 and if_rdata unchanged.
- Contention after reset, both requests at cycle 0, MEM_LAT=1 → if_valid at cycle 3, d_valid at cycle 7. A repeated tie grants fetch next, so grants alternate.
- MEM_LAT=3 fetch → if_valid at cycle 5, with mem_addr held in cycles 1–4.
- Reset pulsed low during WAIT → no valid pulse, busy=0 and rdata registers cleared next cycle. A later held request completes normally.
